// File: rtl/dds_pkg.sv
// Shared constants for the DDS parameter loader: lane sizes, header layout,
// opcodes and the loader FSM state encoding.
package dds_pkg;

    localparam int DDS_NUM_CH = 64;
    localparam int DDS_W      = 16;

    localparam int HDR_OP_MSB  = 15;
    localparam int HDR_OP_LSB  = 14;
    localparam int HDR_IDX_MSB = 5;
    localparam int HDR_IDX_LSB = 0;
    localparam int IDX_W       = HDR_IDX_MSB - HDR_IDX_LSB + 1;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_COMMIT = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_AMP,
        ST_OFF,
        ST_PHW,
        ST_CWAIT
    } state_e;

endpackage

// File: rtl/dds_param_bank.sv
// Shadow/active parameter storage: per-channel shadow write, shadow clear-all,
// and an atomic shadow-to-active commit that drives the packed output buses.
module dds_param_bank
    import dds_pkg::*;
#(
    parameter int NUM_CH = DDS_NUM_CH,
    parameter int W      = DDS_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [W-1:0]        wr_amp,
    input  logic [W-1:0]        wr_off,
    input  logic [W-1:0]        wr_phw,
    input  logic                clr,
    input  logic                commit,
    output logic [NUM_CH*W-1:0] amps,
    output logic [NUM_CH*W-1:0] offsets,
    output logic [NUM_CH*W-1:0] phasewords
);

    logic [W-1:0] sh_amp_q  [NUM_CH];
    logic [W-1:0] sh_off_q  [NUM_CH];
    logic [W-1:0] sh_phw_q  [NUM_CH];
    logic [W-1:0] act_amp_q [NUM_CH];
    logic [W-1:0] act_off_q [NUM_CH];
    logic [W-1:0] act_phw_q [NUM_CH];

    // NOTE: these arrays are reset on purpose -- a reset must leave the generator
    // and the next commit with all-zero lanes, so they stay flops rather than RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sh_amp_q[k]  <= '0;
                sh_off_q[k]  <= '0;
                sh_phw_q[k]  <= '0;
                act_amp_q[k] <= '0;
                act_off_q[k] <= '0;
                act_phw_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                // An index with no matching channel simply decodes to no write.
                if (clr) begin
                    sh_amp_q[k] <= '0;
                    sh_off_q[k] <= '0;
                    sh_phw_q[k] <= '0;
                end else if (wr_en && wr_idx == IDX_W'(k)) begin
                    sh_amp_q[k] <= wr_amp;
                    sh_off_q[k] <= wr_off;
                    sh_phw_q[k] <= wr_phw;
                end
                if (commit) begin
                    act_amp_q[k] <= sh_amp_q[k];
                    act_off_q[k] <= sh_off_q[k];
                    act_phw_q[k] <= sh_phw_q[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign amps[W*k +: W]       = act_amp_q[k];
        assign offsets[W*k +: W]    = act_off_q[k];
        assign phasewords[W*k +: W] = act_phw_q[k];
    end

endmodule

// File: rtl/dds_param_loader.sv
// Host-stream parser that assembles amp/offset/phaseword triples into the shadow
// bank and commits the whole bank to the active buses on a sample-boundary tick.
module dds_param_loader
    import dds_pkg::*;
#(
    parameter int NUM_CH = DDS_NUM_CH,
    parameter int W      = DDS_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sync_tick,
    output logic [NUM_CH*W-1:0] amps,
    output logic [NUM_CH*W-1:0] offsets,
    output logic [NUM_CH*W-1:0] phasewords,
    output logic                commit_done,
    output logic                err_frame
);

    state_e           state_q;
    logic             in_ready_q;
    logic             commit_done_q;
    logic             err_frame_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     amp_q;
    logic [W-1:0]     off_q;

    logic       xfer;
    logic [1:0] op;
    logic       bank_wr;
    logic       bank_clr;
    logic       bank_commit;

    assign xfer        = in_valid && in_ready_q;
    assign op          = in_data[HDR_OP_MSB:HDR_OP_LSB];
    assign bank_wr     = xfer && (state_q == ST_PHW);
    assign bank_clr    = xfer && (state_q == ST_HDR) && (op == OP_CLEAR);
    assign bank_commit = (state_q == ST_CWAIT) && sync_tick;

    // NOTE: non-blocking assignments throughout, so a later assignment in the same
    // block overrides the in_ready_q default without any ordering hazard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_HDR;
            in_ready_q    <= 1'b0;
            commit_done_q <= 1'b0;
            err_frame_q   <= 1'b0;
            idx_q         <= '0;
            amp_q         <= '0;
            off_q         <= '0;
        end else begin
            commit_done_q <= bank_commit;
            // Ready tracks the next state: low only while parked in CWAIT.
            in_ready_q    <= 1'b1;
            case (state_q)
                ST_HDR: begin
                    if (xfer) begin
                        case (op)
                            OP_WRITE: begin
                                idx_q   <= in_data[HDR_IDX_MSB:HDR_IDX_LSB];
                                state_q <= ST_AMP;
                            end
                            OP_COMMIT: begin
                                state_q    <= ST_CWAIT;
                                in_ready_q <= 1'b0;
                            end
                            OP_CLEAR: ;
                            OP_RSVD:  err_frame_q <= 1'b1;
                        endcase
                    end
                end
                ST_AMP: begin
                    if (xfer) begin
                        amp_q   <= in_data;
                        state_q <= ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (xfer) begin
                        off_q   <= in_data;
                        state_q <= ST_PHW;
                    end
                end
                ST_PHW: begin
                    if (xfer) state_q <= ST_HDR;
                end
                ST_CWAIT: begin
                    if (bank_commit) state_q <= ST_HDR;
                    else             in_ready_q <= 1'b0;
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

    dds_param_bank #(
        .NUM_CH (NUM_CH),
        .W      (W)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (bank_wr),
        .wr_idx     (idx_q),
        .wr_amp     (amp_q),
        .wr_off     (off_q),
        .wr_phw     (in_data),
        .clr        (bank_clr),
        .commit     (bank_commit),
        .amps       (amps),
        .offsets    (offsets),
        .phasewords (phasewords)
    );

    assign in_ready    = in_ready_q;
    assign commit_done = commit_done_q;
    assign err_frame   = err_frame_q;

endmodule
